if_prefetch: RTL

//  Parametrised instruction-fetch front end that succeeds the fixed pc_reg + if_id pair.

---
 rtl/if_prefetch_if.sv | 27 ++
 rtl/if_prefetch.sv | 133 +++++++++++++
 2 files changed

// File: rtl/if_prefetch_if.sv
// Instruction bus between the fetch front end and memory.
// Handshake is req&gnt; in-order responses arrive on rvalid.
interface if_prefetch_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction fetch front end: credit-limited pipelined fetch into a
// PC-tagged FIFO, with jump flush and discard of stale responses.
module if_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          jump_en_i,
  input  logic [XLEN-1:0]               jump_addr_i,
  input  logic                          hold_flag_i,
  if_prefetch_if.master                 ibus,
  output logic                          inst_valid_o,
  output logic [31:0]                   inst_o,
  output logic [XLEN-1:0]               inst_addr_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [31:0]     mem_ins [FIFO_DEPTH];
  logic [XLEN-1:0] mem_pc  [FIFO_DEPTH];

  logic [CW:0]     credit_used;
  logic [XLEN-1:0] target;
  logic            hs;
  logic            rv_ok;
  logic            drop;
  logic            push;
  logic            pop;
  logic            unused_lo;

  assign target    = {jump_addr_i[XLEN-1:2], 2'b00};
  assign unused_lo = ^jump_addr_i[1:0];

  // Buffered words plus in-flight requests may never exceed the FIFO size.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign ibus.req    = !rst && !jump_en_i && (credit_used < DEPTH_S);
  assign ibus.addr   = fetch_pc;

  assign hs    = ibus.req && ibus.gnt;
  assign rv_ok = ibus.rvalid && (outstanding != '0);
  assign drop  = discard != '0;
  assign push  = rv_ok && !drop && !jump_en_i;
  assign pop   = (count != '0) && !hold_flag_i && !jump_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (jump_en_i) begin
      fetch_pc <= target;
      resp_pc  <= target;
    end else begin
      if (hs)   fetch_pc <= fetch_pc + XLEN'(4);
      if (push) resp_pc  <= resp_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({hs, rv_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // A jump turns every request still in flight into a discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
    end else if (jump_en_i) begin
      discard <= outstanding - CW'(rv_ok);
    end else if (rv_ok && drop) begin
      discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (jump_en_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ins[wr_ptr] <= ibus.rdata;
      mem_pc[wr_ptr]  <= resp_pc;
    end
  end

  assign inst_valid_o = count != '0;
  assign inst_o       = inst_valid_o ? mem_ins[rd_ptr] : NOP;
  assign inst_addr_o  = inst_valid_o ? mem_pc[rd_ptr] : '0;
  assign fifo_count_o = count;

  a_no_full_push : assert property (
    @(posedge clk) disable iff (rst) !(push && count == DEPTH_C));

  a_no_orphan_rvalid : assert property (
    @(posedge clk) disable iff (rst) !(ibus.rvalid && outstanding == '0));

endmodule
